// File: rtl/llki_discrete_key_driver.sv
// LLKI discrete key initiator: turns load/clear commands into the llkid_* key
// handshakes toward a TSS-wrapped core, with a per-wait timeout and a status pulse.
module llki_discrete_key_driver #(
  parameter int unsigned KEY_WORDS      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [7:0]  cmd_num_words,
  input  logic [63:0] key_word_data,
  input  logic        key_word_valid,
  output logic        key_word_ready,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [63:0] llkid_key_data,
  output logic        llkid_key_valid,
  input  logic        llkid_key_ready,
  input  logic        llkid_key_complete,
  output logic        llkid_clear_key,
  input  logic        llkid_clear_key_ack
);

  localparam int unsigned     TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      MAX_WORDS = 8'(KEY_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SEND, S_WAIT_COMPLETE, S_CLEAR, S_RESP
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_BAD_LEN = 2'b10,
    ST_ALREADY = 2'b11
  } status_e;

  state_e        state_q, state_d;
  status_e       status_q, status_d;
  logic [7:0]    num_q, num_d;
  logic [7:0]    word_cnt_q, word_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [63:0]   key_data_q, key_data_d;
  logic          tmo_hit;

  // A ready/complete/ack seen on the limit cycle wins, so every branch tests
  // the awaited input before tmo_hit.
  assign tmo_hit = (tmo_q == TMO_LAST);

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      status_q   <= ST_OK;
      num_q      <= '0;
      word_cnt_q <= '0;
      tmo_q      <= '0;
      key_data_q <= '0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      num_q      <= num_d;
      word_cnt_q <= word_cnt_d;
      tmo_q      <= tmo_d;
      key_data_q <= key_data_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    num_d      = num_q;
    word_cnt_d = word_cnt_q;
    tmo_d      = tmo_q;
    key_data_d = key_data_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          num_d = cmd_num_words;
          tmo_d = '0;
          if (cmd_op) begin
            state_d = S_CLEAR;
          end else if (cmd_num_words == 8'd0 || cmd_num_words > MAX_WORDS) begin
            state_d  = S_RESP;
            status_d = ST_BAD_LEN;
          end else if (llkid_key_complete) begin
            state_d  = S_RESP;
            status_d = ST_ALREADY;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        if (key_word_valid) begin
          key_data_d = key_word_data;
          tmo_d      = '0;
          state_d    = S_SEND;
        end
      end

      S_SEND: begin
        tmo_d = tmo_q + TW'(1);
        if (llkid_key_ready) begin
          word_cnt_d = word_cnt_q + 8'd1;
          if (word_cnt_q + 8'd1 == num_q) begin
            tmo_d   = '0;
            state_d = S_WAIT_COMPLETE;
          end else begin
            state_d = S_FETCH;
          end
        end else if (tmo_hit) begin
          state_d  = S_RESP;
          status_d = ST_TIMEOUT;
        end
      end

      S_WAIT_COMPLETE: begin
        tmo_d = tmo_q + TW'(1);
        if (llkid_key_complete) begin
          state_d  = S_RESP;
          status_d = ST_OK;
        end else if (tmo_hit) begin
          state_d  = S_RESP;
          status_d = ST_TIMEOUT;
        end
      end

      S_CLEAR: begin
        tmo_d = tmo_q + TW'(1);
        if (llkid_clear_key_ack) begin
          state_d  = S_RESP;
          status_d = ST_OK;
        end else if (tmo_hit) begin
          state_d  = S_RESP;
          status_d = ST_TIMEOUT;
        end
      end

      S_RESP: begin
        word_cnt_d = '0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decode from the registered state only, so an async
  // reset drops all of them immediately.
  always_comb begin
    cmd_ready       = 1'b0;
    key_word_ready  = 1'b0;
    llkid_key_valid = 1'b0;
    llkid_clear_key = 1'b0;
    rsp_valid       = 1'b0;
    case (state_q)
      S_IDLE:  cmd_ready       = 1'b1;
      S_FETCH: key_word_ready  = 1'b1;
      S_SEND:  llkid_key_valid = 1'b1;
      S_CLEAR: llkid_clear_key = 1'b1;
      S_RESP:  rsp_valid       = 1'b1;
      default: ;
    endcase
  end

  assign rsp_status     = status_q;
  assign llkid_key_data = key_data_q;

endmodule

// File: tb/tb_llki_discrete_key_driver.sv
// Self-checking bench for llki_discrete_key_driver: a directed table plus random
// commands, with the bench acting as key source and as the core.
module tb_llki_discrete_key_driver;

  localparam int KW    = 4;
  localparam int T     = 16;
  localparam int NEVER = 1000;
  localparam int BUDGET = 400;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] TMO = 2'b01;
  localparam logic [1:0] BAD = 2'b10;
  localparam logic [1:0] ALR = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [7:0]  cmd_num_words = 8'd0;
  logic [63:0] key_word_data = 64'd0;
  logic        key_word_valid = 1'b0;
  logic        key_word_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [63:0] llkid_key_data;
  logic        llkid_key_valid;
  logic        llkid_key_ready = 1'b0;
  logic        llkid_key_complete = 1'b0;
  logic        llkid_clear_key;
  logic        llkid_clear_key_ack = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  bit key_loaded   = 1'b0;  // the core's own notion of a loaded key
  bit model_loaded = 1'b0;  // reference model's prediction of the same

  typedef struct {
    logic [1:0] st;
    int         hs;
    int         rsp_cnt;
    int         rsp_cyc;
    int         max_vrun;
    int         clr_cyc;
    bit         order_ok;
    bit         timed_out;
    logic       ready_after;
  } obs_t;

  typedef struct {
    bit         op;
    int         num;
    int         gap;
    int         rdy;
    int         cmp;
    int         ack;
    logic [1:0] st;
    int         hs;
  } vec_t;

  llki_discrete_key_driver #(.KEY_WORDS(KW), .TIMEOUT_CYCLES(T)) dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_op             (cmd_op),
    .cmd_num_words      (cmd_num_words),
    .key_word_data      (key_word_data),
    .key_word_valid     (key_word_valid),
    .key_word_ready     (key_word_ready),
    .rsp_valid          (rsp_valid),
    .rsp_status         (rsp_status),
    .llkid_key_data     (llkid_key_data),
    .llkid_key_valid    (llkid_key_valid),
    .llkid_key_ready    (llkid_key_ready),
    .llkid_key_complete (llkid_key_complete),
    .llkid_clear_key    (llkid_clear_key),
    .llkid_clear_key_ack(llkid_clear_key_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Outcome of one command derived from the protocol rules alone: latencies are
  // counted in cycles after valid/clear rises, and a response on the last of the
  // T allowed cycles still succeeds.
  function automatic void model(input bit op, input int num, input int rdy, input int cmp,
                                input int ack, inout bit loaded,
                                output logic [1:0] st, output int hs, output int vrun,
                                output int clr, output int lat);
    hs = 0; vrun = 0; clr = 0; lat = -1;
    if (op) begin
      if (ack < T) begin st = OK; clr = ack + 1; loaded = 1'b0; end
      else         begin st = TMO; clr = T; end
    end else if (num < 1 || num > KW) begin
      st = BAD; lat = 1;
    end else if (loaded) begin
      st = ALR; lat = 1;
    end else if (rdy >= T) begin
      st = TMO; vrun = T;
    end else begin
      hs = num; vrun = rdy + 1;
      if (cmp < T) begin st = OK; loaded = 1'b1; end
      else         st = TMO;
    end
  endfunction

  // Issue one command and play source and core until the response and one more cycle.
  task automatic run_cmd(input bit op, input int num, input int gap, input int rdy_lat,
                         input int cmp_lat, input int ack_lat, input logic [63:0] w0,
                         output obs_t o);
    logic [63:0] src [KW];
    int src_idx = 0, gap_cnt = 0, vrun = 0, crun = 0, wcyc = 0, got = 0, cyc = 0;
    bit waiting = 1'b0, seen = 1'b0, done = 1'b0;
    o = '{st: 2'bxx, hs: 0, rsp_cnt: 0, rsp_cyc: -1, max_vrun: 0, clr_cyc: 0,
          order_ok: 1'b1, timed_out: 1'b0, ready_after: 1'bx};
    src[0] = w0;
    for (int i = 1; i < KW; i++) src[i] = {$urandom, $urandom};

    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_num_words = 8'(num);
    while (cyc < BUDGET) begin
      if (cyc > 0) cmd_valid = 1'b0;
      key_word_valid = (src_idx < KW) && (gap_cnt == 0);
      key_word_data  = (src_idx < KW) ? src[src_idx] : 64'd0;
      vrun = llkid_key_valid ? vrun + 1 : 0;
      if (vrun > o.max_vrun) o.max_vrun = vrun;
      llkid_key_ready = llkid_key_valid && (vrun > rdy_lat);
      crun = llkid_clear_key ? crun + 1 : 0;
      llkid_clear_key_ack = llkid_clear_key && (crun > ack_lat);
      if (waiting) begin
        if (wcyc >= cmp_lat) key_loaded = 1'b1;
        wcyc++;
      end
      llkid_key_complete = key_loaded;

      @(negedge clk);
      if (rsp_valid) o.rsp_cnt++;
      if (seen) begin
        o.ready_after = cmd_ready;
        done = 1'b1;
      end else begin
        if (llkid_clear_key) o.clr_cyc++;
        if (key_word_valid && key_word_ready) begin
          src_idx++;
          gap_cnt = gap;
        end else if (gap_cnt > 0) begin
          gap_cnt--;
        end
        if (llkid_key_valid && llkid_key_ready) begin
          if (got >= KW || llkid_key_data !== src[got]) o.order_ok = 1'b0;
          got++;
          o.hs++;
          if (o.hs == num) begin waiting = 1'b1; wcyc = 0; end
        end
        if (llkid_clear_key && llkid_clear_key_ack) key_loaded = 1'b0;
        if (rsp_valid) begin seen = 1'b1; o.st = rsp_status; o.rsp_cyc = cyc; end
      end
      @(posedge clk); #1;
      cyc++;
      if (done) break;
    end
    o.timed_out = !done;
    cmd_valid = 1'b0; key_word_valid = 1'b0; llkid_key_ready = 1'b0;
    llkid_clear_key_ack = 1'b0; llkid_key_complete = key_loaded;
  endtask

  task automatic apply(input string tag, input bit op, input int num, input int gap,
                       input int rdy, input int cmp, input int ack, input logic [63:0] w0,
                       input bit use_tbl, input logic [1:0] tbl_st, input int tbl_hs);
    obs_t o;
    logic [1:0] m_st;
    int m_hs, m_vrun, m_clr, m_lat;
    model(op, num, rdy, cmp, ack, model_loaded, m_st, m_hs, m_vrun, m_clr, m_lat);
    run_cmd(op, num, gap, rdy, cmp, ack, w0, o);
    check({tag, " finished"}, 64'(o.timed_out), 64'd0);
    check({tag, " status"},   64'(o.st), use_tbl ? 64'(tbl_st) : 64'(m_st));
    check({tag, " llkid handshakes"}, 64'(o.hs), use_tbl ? 64'(tbl_hs) : 64'(m_hs));
    check({tag, " rsp pulses"}, 64'(o.rsp_cnt), 64'd1);
    check({tag, " word order"}, 64'(o.order_ok), 64'd1);
    check({tag, " valid run"},  64'(o.max_vrun), 64'(m_vrun));
    check({tag, " clear cycles"}, 64'(o.clr_cyc), 64'(m_clr));
    check({tag, " cmd_ready after rsp"}, 64'(o.ready_after), 64'd1);
    if (m_lat >= 0) check({tag, " rsp latency"}, 64'(o.rsp_cyc), 64'(m_lat));
  endtask

  function automatic int pick_lat();
    case ($urandom_range(0, 5))
      0, 1, 2, 3: return int'($urandom_range(0, 3));
      4:          return T - 1;
      default:    return NEVER;
    endcase
  endfunction

  initial begin
    vec_t tbl [13];
    int   n_valid;
    int   n_rsp;

    tbl[0]  = '{1'b0, 1, 0, 3, 2,     0,     OK,  1};  // single word, slow core
    tbl[1]  = '{1'b0, 2, 0, 0, 0,     0,     ALR, 0};  // key already loaded
    tbl[2]  = '{1'b1, 0, 0, 0, 0,     4,     OK,  0};  // clear, ack after 4
    tbl[3]  = '{1'b0, 4, 1, 0, 1,     0,     OK,  4};  // gapped source
    tbl[4]  = '{1'b1, 0, 0, 0, 0,     T-1,   OK,  0};  // ack on the limit cycle
    tbl[5]  = '{1'b0, 0, 0, 0, 0,     0,     BAD, 0};
    tbl[6]  = '{1'b0, 5, 0, 0, 0,     0,     BAD, 0};
    tbl[7]  = '{1'b0, 2, 0, NEVER, 0, 0,     TMO, 0};  // core never ready
    tbl[8]  = '{1'b0, 1, 0, T-1, T-1, 0,     OK,  1};  // ready and complete on limit
    tbl[9]  = '{1'b1, 0, 0, 0, 0,     NEVER, TMO, 0};  // clear never acked
    tbl[10] = '{1'b0, 3, 0, 0, 0,     0,     ALR, 0};
    tbl[11] = '{1'b1, 0, 0, 0, 0,     0,     OK,  0};  // ack on first cycle
    tbl[12] = '{1'b0, 3, 2, 1, NEVER, 0,     TMO, 3};  // complete never comes

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset cmd_ready",       64'(cmd_ready), 64'd1);
    check("reset key_word_ready",  64'(key_word_ready), 64'd0);
    check("reset rsp_valid",       64'(rsp_valid), 64'd0);
    check("reset rsp_status",      64'(rsp_status), 64'd0);
    check("reset llkid_key_valid", 64'(llkid_key_valid), 64'd0);
    check("reset llkid_key_data",  llkid_key_data, 64'd0);
    check("reset llkid_clear_key", 64'(llkid_clear_key), 64'd0);

    for (int i = 0; i < 13; i++)
      apply($sformatf("tbl%0d", i), tbl[i].op, tbl[i].num, tbl[i].gap, tbl[i].rdy,
            tbl[i].cmp, tbl[i].ack, 64'h0123_4567_89AB_CDEF, 1'b1, tbl[i].st, tbl[i].hs);

    // Reset while word 2 of 4 is being offered to a stalled core.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_num_words = 8'd4;
    key_word_valid = 1'b1; key_word_data = 64'hA5A5_0000_5A5A_FFFF;
    n_valid = 0;
    for (int i = 0; i < 20 && n_valid < 2; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (llkid_key_valid) n_valid++;
      llkid_key_ready = llkid_key_valid && (n_valid == 1);
    end
    check("rst test reached word 2", 64'(n_valid), 64'd2);
    #2 rst = 1'b1;
    #1;
    check("rst async llkid_key_valid", 64'(llkid_key_valid), 64'd0);
    check("rst async key_word_ready",  64'(key_word_ready), 64'd0);
    check("rst async rsp_valid",       64'(rsp_valid), 64'd0);
    key_word_valid = 1'b0; llkid_key_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_rsp = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    check("rst no response", 64'(n_rsp), 64'd0);
    check("rst cmd_ready",   64'(cmd_ready), 64'd1);
    apply("after rst", 1'b0, 2, 0, 0, 0, 0, 64'hFEED_FACE_CAFE_BEEF, 1'b0, OK, 0);

    for (int i = 0; i < 40; i++) begin
      bit op;
      int num;
      op  = ($urandom_range(0, 3) == 0);
      num = int'($urandom_range(0, KW + 1));
      apply($sformatf("rnd%0d", i), op, num, int'($urandom_range(0, 2)), pick_lat(),
            pick_lat(), pick_lat(), {$urandom, $urandom}, 1'b0, OK, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
